// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the multi-word add sequencer.
// Holds the slice width, the sequencer state type and the index-width helper.
package multiword_add_seq_pkg;

    // Width of one operand slice handled by the adder per cycle.
    localparam int SLICE_W = 16;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of bits needed to index WORDS slices (at least one bit).
    function automatic int idx_width(input int words);
        if (words > 1) begin
            return $clog2(words);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/carry_bypass_adder16.sv
// 16-bit carry-bypass adder built from four 4-bit ripple blocks.
// A block whose bits all propagate forwards its incoming carry directly.
module carry_bypass_adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic        blk_c_s;
    logic        rip_c_s;
    logic        prop_s;
    logic        p_s;
    logic [15:0] sum_s;

    // Ripple inside each block, bypass the block carry when it fully propagates.
    always_comb begin
        blk_c_s = cin;
        rip_c_s = 1'b0;
        prop_s  = 1'b0;
        p_s     = 1'b0;
        sum_s   = 16'h0000;
        for (int blk = 0; blk < 4; blk++) begin
            rip_c_s = blk_c_s;
            prop_s  = 1'b1;
            for (int bi = 0; bi < 4; bi++) begin
                p_s                = a[blk*4+bi] ^ b[blk*4+bi];
                sum_s[blk*4+bi]    = p_s ^ rip_c_s;
                rip_c_s            = (a[blk*4+bi] & b[blk*4+bi]) | (p_s & rip_c_s);
                prop_s             = prop_s & p_s;
            end
            if (prop_s) begin
                blk_c_s = blk_c_s;
            end else begin
                blk_c_s = rip_c_s;
            end
        end
    end

    assign sum  = sum_s;
    assign cout = blk_c_s;

endmodule

// File: rtl/multiword_add_seq.sv
// Multi-word adder sequencer: streams WORDS 16-bit slices (LSW first)
// through one carry_bypass_adder16, chaining the carry between slices.
// Optional feature macro: MULTIWORD_ADD_SEQ_OVF_EN adds the out_ovf
// signed-overflow output.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SLICE_W*WORDS-1:0] in_a,
    input  logic [SLICE_W*WORDS-1:0] in_b,
    input  logic                     in_cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SLICE_W*WORDS-1:0] out_sum,
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    output logic                     out_ovf,
`endif
    output logic                     out_cout
);

    localparam int OP_W  = SLICE_W * WORDS;
    localparam int IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    state_e            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic              carry_q;
    logic [OP_W-1:0]   op_a_q;
    logic [OP_W-1:0]   op_b_q;
    logic [OP_W-1:0]   sum_q;
    logic              cout_q;
    logic              valid_q;

    logic [SLICE_W-1:0] add_a_s;
    logic [SLICE_W-1:0] add_b_s;
    logic [SLICE_W-1:0] add_sum_s;
    logic               add_cout_s;

`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    logic ovf_q;
    logic ovf_s;
`endif

    // Select the current slice of the latched operands for the adder.
    assign add_a_s = op_a_q[idx_q*SLICE_W +: SLICE_W];
    assign add_b_s = op_b_q[idx_q*SLICE_W +: SLICE_W];

    carry_bypass_adder16 u_adder (
        .a    (add_a_s),
        .b    (add_b_s),
        .cin  (carry_q),
        .cout (add_cout_s),
        .sum  (add_sum_s)
    );

`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    // Signed overflow: carry into the MSB (recovered from sum/a/b) vs carry out.
    assign ovf_s = (add_sum_s[SLICE_W-1] ^ add_a_s[SLICE_W-1] ^ add_b_s[SLICE_W-1]) ^ add_cout_s;
`endif

    // Next slice index, wrapping to zero after the last slice.
    always_comb begin
        if (idx_q == IDX_LAST) begin
            idx_d = '0;
        end else begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    // Sequencer FSM with registered result, carry chain and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_a_q  <= in_a;
                        op_b_q  <= in_b;
                        carry_q <= in_cin;
                        idx_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_q[idx_q*SLICE_W +: SLICE_W] <= add_sum_s;
                    carry_q <= add_cout_s;
                    idx_q   <= idx_d;
                    if (idx_q == IDX_LAST) begin
                        cout_q  <= add_cout_s;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
                        ovf_q   <= ovf_s;
`endif
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    idx_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq with WORDS=4 (64-bit operands).
module tb_multiword_add_seq;

    localparam int WORDS = 4;
    localparam int OW    = 16 * WORDS;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] in_a;
    logic [OW-1:0] in_b;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_sum;
    logic          out_cout;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    logic          out_ovf;
`endif

    typedef struct packed {
        logic [OW-1:0] sum;
        logic          cout;
        logic          ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    multiword_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .out_cout  (out_cout)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk_exp(input logic [OW-1:0] s, input logic c, input logic o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        return e;
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each handed-off result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {{(OW-1){1'b0}}, out_valid}, {OW{1'b0}});
            end else begin
                mon_e = exp_q.pop_front();
                check("sum", out_sum, mon_e.sum);
                check("cout", {{(OW-1){1'b0}}, out_cout}, {{(OW-1){1'b0}}, mon_e.cout});
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
                check("ovf", {{(OW-1){1'b0}}, out_ovf}, {{(OW-1){1'b0}}, mon_e.ovf});
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer an operand pair and return just after the accept edge.
    task automatic accept(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic c);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("accept_ready", {{(OW-1){1'b0}}, in_ready}, {{(OW-1){1'b0}}, 1'b1});
        tick();
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        in_cin   = ~c;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic c,
                         input logic [OW-1:0] es, input logic ec, input logic eo);
        int lat;
        exp_q.push_back(mk_exp(es, ec, eo));
        accept(a, b, c);
        wait_valid(lat);
        check("latency", OW'(lat), OW'(WORDS));
        tick();
        check("idle_in_ready", {{(OW-1){1'b0}}, in_ready}, {{(OW-1){1'b0}}, 1'b1});
        check("idle_out_valid", {{(OW-1){1'b0}}, out_valid}, {OW{1'b0}});
    endtask

    logic [OW-1:0] va [6];
    logic [OW-1:0] vb [6];
    logic          vc [6];
    logic [OW-1:0] vs [6];
    logic          vco[6];
    logic          vo [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int n_acc;
        int acc_cyc[4];
        int n;

        // Directed vectors: A, B, cin, expected sum, cout, ovf.
        va[0] = 64'h0000_0000_0000_0003; vb[0] = 64'h0000_0000_0000_0004; vc[0] = 1'b0;
        vs[0] = 64'h0000_0000_0000_0007; vco[0] = 1'b0; vo[0] = 1'b0;
        va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'h0000_0000_0000_0000; vc[1] = 1'b1;
        vs[1] = 64'h0000_0000_0000_0000; vco[1] = 1'b1; vo[1] = 1'b0;
        va[2] = 64'h7FFF_FFFF_FFFF_FFFF; vb[2] = 64'h0000_0000_0000_0001; vc[2] = 1'b0;
        vs[2] = 64'h8000_0000_0000_0000; vco[2] = 1'b0; vo[2] = 1'b1;
        va[3] = 64'h1234_5678_9ABC_DEF0; vb[3] = 64'h1111_1111_1111_1111; vc[3] = 1'b0;
        vs[3] = 64'h2345_6789_ABCD_F001; vco[3] = 1'b0; vo[3] = 1'b0;
        va[4] = 64'h8000_0000_0000_0000; vb[4] = 64'h8000_0000_0000_0000; vc[4] = 1'b1;
        vs[4] = 64'h0000_0000_0000_0001; vco[4] = 1'b1; vo[4] = 1'b1;
        va[5] = 64'hFFFF_0000_FFFF_0000; vb[5] = 64'h0001_0000_0001_0000; vc[5] = 1'b0;
        vs[5] = 64'h0000_0001_0000_0000; vco[5] = 1'b1; vo[5] = 1'b0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", {{(OW-1){1'b0}}, in_ready}, {{(OW-1){1'b0}}, 1'b1});
        check("rst_out_valid", {{(OW-1){1'b0}}, out_valid}, {OW{1'b0}});
        check("rst_out_sum", out_sum, {OW{1'b0}});
        check("rst_out_cout", {{(OW-1){1'b0}}, out_cout}, {OW{1'b0}});
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], vc[i], vs[i], vco[i], vo[i]);
        end

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        exp_q.push_back(mk_exp(64'h0000_0000_0000_0100, 1'b0, 1'b0));
        accept(64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0001, 1'b0);
        wait_valid(lat);
        check("bp_latency", OW'(lat), OW'(WORDS));
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", {{(OW-1){1'b0}}, out_valid}, {{(OW-1){1'b0}}, 1'b1});
            check("bp_out_sum", out_sum, 64'h0000_0000_0000_0100);
            check("bp_in_ready", {{(OW-1){1'b0}}, in_ready}, {OW{1'b0}});
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", {{(OW-1){1'b0}}, out_valid}, {OW{1'b0}});
        check("bp_release_ready", {{(OW-1){1'b0}}, in_ready}, {{(OW-1){1'b0}}, 1'b1});

        // Reset on the second RUN cycle aborts the operation.
        accept(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        check("abort_out_valid", {{(OW-1){1'b0}}, out_valid}, {OW{1'b0}});
        check("abort_in_ready", {{(OW-1){1'b0}}, in_ready}, {{(OW-1){1'b0}}, 1'b1});
        check("abort_out_sum", out_sum, {OW{1'b0}});
        rst = 1'b0;
        do_op(64'd5, 64'd6, 1'b0, 64'h0000_0000_0000_000B, 1'b0, 1'b0);

        // Back-to-back with in_valid held high.
        n_acc    = 0;
        in_valid = 1'b1;
        in_a     = 64'd1;
        in_b     = 64'd2;
        in_cin   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (in_ready) begin
                if (n_acc < 4) acc_cyc[n_acc] = c;
                if (n_acc == 0) exp_q.push_back(mk_exp(64'd3, 1'b0, 1'b0));
                if (n_acc == 1) exp_q.push_back(mk_exp(64'h30, 1'b0, 1'b0));
                n_acc++;
                tick();
                if (n_acc == 1) begin
                    in_a = 64'h10;
                    in_b = 64'h20;
                end
            end else begin
                tick();
            end
        end
        in_valid = 1'b0;
        check("b2b_accepts", OW'(n_acc), OW'(2));
        if (n_acc >= 2) begin
            check("b2b_spacing", OW'(acc_cyc[1] - acc_cyc[0]), OW'(WORDS + 2));
        end
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        tick();
        check("queue_drained", OW'(exp_q.size()), {OW{1'b0}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
- Sequencer wrapped around one existing 16-bit carry-bypass adder (`carry_bypass_adder16`).
- Accepts a WORDS×16-bit operand pair and carry-in over a valid/ready handshake.
- Feeds one 16-bit slice per cycle into the adder, LSW first, chaining the adder's cout back into its cin.
- Returns the full-width sum and final carry over a second valid/ready handshake.
- Sits directly upstream/downstream of the adder: it both drives the adder's a/b/cin and consumes its sum/cout.

Parameters:
- WORDS, 4, number of 16-bit slices per operand (legal 2..16); operand width = 16*WORDS.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept operands.
- in_a  input  16*WORDS  operand A.
- in_b  input  16*WORDS  operand B.
- in_cin  input  1  carry-in to slice 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_sum  output  16*WORDS  result, A+B+cin mod 2^(16*WORDS).
- out_cout  output  1  carry out of the top slice.

Interface (already decided):
- One clock; reset is synchronous and active-high.

Behaviour:
- FSM states: IDLE, RUN, DONE. Encoding is free.
- Reset values (rst sampled high at a clk edge):
  - state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0.
  - slice index=0, carry register=0, operand registers=0.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid&in_ready: latch in_a, in_b into registers; carry register<=in_cin; idx<=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Adder inputs: a=A[16*idx+:16], b=B[16*idx+:16], cin=carry register.
  - Each edge: result register slice idx <= adder sum; carry register <= adder cout; idx<=idx+1.
  - When idx==WORDS-1 at the edge: out_cout <= adder cout; go to DONE.
- DONE:
  - out_valid=1; out_sum and out_cout held stable.
  - On the edge where out_valid&out_ready: go to IDLE. out_sum/out_cout keep their last value; they are only meaningful while out_valid=1.
- Latency: out_valid rises exactly WORDS cycles after the input-accept edge.
- Throughput: one operation per WORDS+2 cycles when out_ready is held high (accept edge, WORDS RUN cycles, DONE/handshake cycle, IDLE cycle).
- in_ready is combinationally (state==IDLE). No input is accepted in RUN or DONE.
- in_a/in_b/in_cin may change freely after acceptance; the latched copies are used.
- out_ready low in DONE: hold indefinitely. No data loss, no re-computation.
- rst high in any state (including mid-RUN): abort, return to reset values on that edge. A partially computed result is discarded and never presented.
- rst and in_valid high on the same edge: rst wins, nothing is accepted.
- Arithmetic: pure unsigned modular addition. Wrap-around of the top slice is reported only via out_cout.
- idx width: clog2(WORDS). idx never exceeds WORDS-1.

Optional Feature:
- Macro: MULTIWORD_ADD_SEQ_OVF_EN.
- Defined:
  - Extra output port out_ovf (1 bit), two's-complement signed overflow of the full-width add.
  - out_ovf = carry into MSB xor carry out of MSB, computed during the last RUN cycle.
  - Registered and held alongside out_sum; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package multiword_add_seq_pkg:
  - localparam SLICE_W=16.
  - Typedef for the state enum (IDLE/RUN/DONE).
  - Function returning the idx width from WORDS.
- Sub-module: exactly one instance of the existing `carry_bypass_adder16` (ports a, b, cin, cout, sum). No other datapath sub-modules; no arithmetic beyond the instance and the overflow xor.

Test Plan:
- Basic add, WORDS=4: A=0x0000_0000_0000_0003, B=0x0000_0000_0000_0004, cin=0, out_ready=1 -> out_valid 4 cycles after accept; out_sum=0x...0007, out_cout=0.
- Full carry ripple across all slices: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> out_sum=0, out_cout=1. With OVF_EN: out_ovf=0.
- Signed overflow (OVF_EN): A=0x7FFF_FFFF_FFFF_FFFF, B=1, cin=0 -> out_sum=0x8000_0000_0000_0000, out_cout=0, out_ovf=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out_sum stable, in_ready=0 throughout. Raise out_ready -> IDLE next edge, in_ready=1.
- Reset mid-RUN: assert rst on the 2nd RUN cycle -> next edge out_valid=0, in_ready=1, out_sum=0. A new op A=5, B=6 then yields 0xB, with no residue from the aborted op.
- Back-to-back: in_valid held high with out_ready=1 across two ops -> second op accepted only in IDLE. Accepts spaced WORDS+2 cycles apart; both results correct, no extra acceptances.
